simul_axi_read_arb: RTL and testbench

Simulation-side read-channel arbiter that shares one AXI read address channel between NUM_REQ requesters. It sits ahead of the read-burst checker/address generator. It issues one address+length command at a time with round-robin fairness and records the grant order. Returned data beats are routed back to the owning requester, and length/last consistency is checked per burst.

---
 rtl/simul_axi_pkg.sv | 20 ++
 rtl/simul_axi_order_fifo.sv | 66 ++++++
 rtl/simul_axi_read_arb.sv | 149 ++++++++++++++
 tb/tb_simul_axi_read_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/simul_axi_pkg.sv
// Shared defaults and helpers for the simulation-side AXI read arbiter.
// The owner-id width and the FIFO pointer widths are all derived through clog2.
package simul_axi_pkg;

    localparam int NUM_REQ_DEF     = 4;
    localparam int ORDER_DEPTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF  = 10;
    localparam int LEN_WIDTH_DEF   = 4;

    // Ceiling log2; callers only pass n >= 2, so the result is at least 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/simul_axi_order_fifo.sv
// FIFO of {owner id, burst length} entries, in the order the AR channel accepted them.
// The head entry is read combinationally so that returning beats can be routed in the same cycle.
module simul_axi_order_fifo
    import simul_axi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [clog2(DEPTH):0]    count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr_q];

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/simul_axi_read_arb.sv
// Round-robin arbiter sharing one AXI read address channel between NUM_REQ requesters,
// routing returned beats back to the owner of each burst and checking RLAST against the burst length.
module simul_axi_read_arb
    import simul_axi_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int ORDER_DEPTH = ORDER_DEPTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH   = LEN_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            ar_valid,
    output logic [ADDR_WIDTH-1:0]           ar_addr,
    output logic [LEN_WIDTH-1:0]            ar_len,
    input  logic                            ar_ready,
    input  logic                            data_stb,
    input  logic                            last,
    output logic [NUM_REQ-1:0]              rd_stb,
    output logic                            rd_last,
    output logic [clog2(ORDER_DEPTH):0]     outstanding,
    output logic                            err
);

    localparam int ID_W  = clog2(NUM_REQ);
    localparam int ENT_W = ID_W + LEN_WIDTH;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0]  len_arr  [NUM_REQ];

    logic                  ar_valid_q, ar_valid_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [LEN_WIDTH-1:0]  ar_len_q, ar_len_d;
    logic [ID_W-1:0]       ar_id_q, ar_id_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  grant_ok, win_found, grant;
    logic [ID_W-1:0]       win_id;
    logic                  ar_xfer;

    logic [ENT_W-1:0]      fifo_head;
    logic [ID_W-1:0]       head_id;
    logic [LEN_WIDTH-1:0]  head_len;
    logic                  fifo_full, fifo_empty, pop;
    logic [clog2(ORDER_DEPTH):0] fifo_count;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign len_arr[gi]  = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
            assign rd_stb[gi]   = data_stb & ~fifo_empty & (int'(head_id) == gi);
        end
    endgenerate

    assign ar_xfer  = ar_valid_q & ar_ready;
    assign {head_id, head_len} = fifo_head;
    assign rd_last  = ~fifo_empty & (cnt_q == head_len);
    assign pop      = data_stb & rd_last;

    // A transferring slot still counts toward capacity, so the FIFO can never be pushed while full.
    // Gating with rst_n keeps req_ready low for the whole reset interval.
    assign grant_ok = rst_n & (~ar_valid_q | ar_ready)
                    & ((int'(fifo_count) + int'(ar_valid_q)) < ORDER_DEPTH);

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        grant     = grant_ok & win_found;
        req_ready = '0;
        if (grant) req_ready[win_id] = 1'b1;
    end

    always_comb begin
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_id_d    = ar_id_q;
        ptr_d      = ptr_q;
        if (ar_xfer) ar_valid_d = 1'b0;
        if (grant) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = addr_arr[win_id];
            ar_len_d   = len_arr[win_id];
            ar_id_d    = win_id;
            ptr_d      = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (data_stb && !fifo_empty) cnt_d = rd_last ? '0 : cnt_q + 1'b1;
        err_d = data_stb & (fifo_empty | (last != rd_last));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_id_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_id_q    <= ar_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    simul_axi_order_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ar_xfer),
        .push_data ({ar_id_q, ar_len_q}),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ar_valid    = ar_valid_q;
    assign ar_addr     = ar_addr_q;
    assign ar_len      = ar_len_q;
    assign outstanding = fifo_count;
    assign err         = err_q;

endmodule

// File: tb/tb_simul_axi_read_arb.sv
// Directed bench for simul_axi_read_arb: grant, fairness, capacity, routing, error and reset cases.
module tb_simul_axi_read_arb;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     req_ready;
    logic              ar_valid;
    logic [AW-1:0]     ar_addr;
    logic [LW-1:0]     ar_len;
    logic              ar_ready;
    logic              data_stb;
    logic              last;
    logic [NR-1:0]     rd_stb;
    logic              rd_last;
    logic [4:0]        outstanding;
    logic              err;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    simul_axi_read_arb #(
        .NUM_REQ(NR), .ORDER_DEPTH(16), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_len(ar_len), .ar_ready(ar_ready),
        .data_stb(data_stb), .last(last), .rd_stb(rd_stb), .rd_last(rd_last),
        .outstanding(outstanding), .err(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_len = '0;
        ar_ready = 1'b0; data_stb = 1'b0; last = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        vectors++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL reset_ar_valid got=%b exp=0", ar_valid); end
        vectors++; if (ar_addr !== 10'h000) begin errors++; $display("FAIL reset_ar_addr got=%h exp=000", ar_addr); end
        vectors++; if (ar_len !== 4'h0) begin errors++; $display("FAIL reset_ar_len got=%h exp=0", ar_len); end
        vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        vectors++; if (rd_stb !== 4'b0000 || rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b/%b exp=0000/0", rd_stb, rd_last); end
        vectors++; if (outstanding !== 5'd0 || err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%0d/%b exp=0/0", outstanding, err); end
        $display("test_reset done");
    endtask

    task automatic test_single;
        do_reset();
        req_addr[0*AW +: AW] = 10'h040; req_len[0*LW +: LW] = 4'd3;
        req_valid = 4'b0001; ar_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        tick(); req_valid = 4'b0000; #1;
        vectors++; if (ar_valid !== 1'b1 || ar_addr !== 10'h040 || ar_len !== 4'd3) begin errors++; $display("FAIL single_ar got=%b/%h/%0d exp=1/040/3", ar_valid, ar_addr, ar_len); end
        vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_no_regrant got=%b exp=0000", req_ready); end
        tick();
        vectors++; if (outstanding !== 5'd1) begin errors++; $display("FAIL single_outstanding got=%0d exp=1", outstanding); end
        for (int b = 0; b < 4; b++) begin
            data_stb = 1'b1; last = (b == 3); #1;
            vectors++; if (rd_stb !== 4'b0001 || rd_last !== (b == 3)) begin errors++; $display("FAIL single_beat%0d got=%b/%b exp=0001/%0d", b, rd_stb, rd_last, (b == 3)); end
            tick();
        end
        data_stb = 1'b0; last = 1'b0; #1;
        vectors++; if (err !== 1'b0 || outstanding !== 5'd0) begin errors++; $display("FAIL single_done got err=%b out=%0d exp=0/0", err, outstanding); end
        $display("test_single done");
    endtask

    task automatic test_fairness;
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        logic [NR-1:0] exp;
        do_reset();
        req_valid = 4'b1111; ar_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp = 4'b0001 << exp_seq[i];
            vectors++; if (req_ready !== exp) begin errors++; $display("FAIL fair_grant%0d got=%b exp=%b", i, req_ready, exp); end
            tick();
        end
        req_valid = 4'b0000;
        $display("test_fairness done");
    endtask

    task automatic test_full;
        int xfers = 0;
        int grants = 0;
        do_reset();
        req_valid = 4'b0001; ar_ready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (ar_valid && ar_ready) xfers++;
            if (req_ready != 4'b0000) grants++;
            tick();
        end
        #1;
        vectors++; if (xfers !== 16 || grants !== 16) begin errors++; $display("FAIL full_count got xfers=%0d grants=%0d exp=16/16", xfers, grants); end
        vectors++; if (req_ready !== 4'b0000 || ar_valid !== 1'b0 || outstanding !== 5'd16) begin errors++; $display("FAIL full_stall got=%b/%b/%0d exp=0000/0/16", req_ready, ar_valid, outstanding); end
        data_stb = 1'b1; last = 1'b1; #1;
        vectors++; if (rd_stb !== 4'b0001 || rd_last !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL full_beat got=%b/%b/%b exp=0001/1/0000", rd_stb, rd_last, req_ready); end
        tick(); data_stb = 1'b0; last = 1'b0; #1;
        vectors++; if (req_ready !== 4'b0001 || outstanding !== 5'd15) begin errors++; $display("FAIL full_refill got=%b/%0d exp=0001/15", req_ready, outstanding); end
        tick();
        grants = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (req_ready != 4'b0000) grants++;
            tick();
        end
        vectors++; if (grants !== 0 || outstanding !== 5'd16) begin errors++; $display("FAIL full_one_only got grants=%0d out=%0d exp=0/16", grants, outstanding); end
        req_valid = 4'b0000;
        $display("test_full done");
    endtask

    task automatic test_interleave;
        do_reset();
        ar_ready = 1'b1;
        req_addr[2*AW +: AW] = 10'h100; req_len[2*LW +: LW] = 4'd0;
        req_addr[1*AW +: AW] = 10'h200; req_len[1*LW +: LW] = 4'd1;
        req_valid = 4'b0100; #1;
        vectors++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL il_grant2 got=%b exp=0100", req_ready); end
        tick(); req_valid = 4'b0010; #1;
        vectors++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL il_grant1 got=%b exp=0010", req_ready); end
        tick(); req_valid = 4'b0000;
        tick();
        data_stb = 1'b1; last = 1'b1; #1;
        vectors++; if (rd_stb !== 4'b0100 || rd_last !== 1'b1) begin errors++; $display("FAIL il_beat0 got=%b/%b exp=0100/1", rd_stb, rd_last); end
        tick(); last = 1'b0; #1;
        vectors++; if (rd_stb !== 4'b0010 || rd_last !== 1'b0) begin errors++; $display("FAIL il_beat1 got=%b/%b exp=0010/0", rd_stb, rd_last); end
        tick(); last = 1'b1; #1;
        vectors++; if (rd_stb !== 4'b0010 || rd_last !== 1'b1) begin errors++; $display("FAIL il_beat2 got=%b/%b exp=0010/1", rd_stb, rd_last); end
        tick(); data_stb = 1'b0; last = 1'b0; #1;
        vectors++; if (err !== 1'b0 || outstanding !== 5'd0) begin errors++; $display("FAIL il_done got err=%b out=%0d exp=0/0", err, outstanding); end
        $display("test_interleave done");
    endtask

    task automatic test_errors;
        do_reset();
        ar_ready = 1'b1;
        req_addr[0*AW +: AW] = 10'h080; req_len[0*LW +: LW] = 4'd3;
        req_valid = 4'b0001;
        tick(); req_valid = 4'b0000;
        tick();
        data_stb = 1'b1; last = 1'b0; tick();
        last = 1'b1; tick();
        data_stb = 1'b0; last = 1'b0; #1;
        vectors++; if (err !== 1'b1) begin errors++; $display("FAIL err_early_last got=%b exp=1", err); end
        data_stb = 1'b1; tick();
        data_stb = 1'b0; #1;
        vectors++; if (err !== 1'b0) begin errors++; $display("FAIL err_clears got=%b exp=0", err); end
        data_stb = 1'b1; last = 1'b1; tick();
        data_stb = 1'b0; last = 1'b0; #1;
        vectors++; if (err !== 1'b0 || outstanding !== 5'd0) begin errors++; $display("FAIL err_burst_end got err=%b out=%0d exp=0/0", err, outstanding); end
        data_stb = 1'b1; #1;
        vectors++; if (rd_stb !== 4'b0000 || rd_last !== 1'b0) begin errors++; $display("FAIL err_stray_route got=%b/%b exp=0000/0", rd_stb, rd_last); end
        tick(); data_stb = 1'b0; #1;
        vectors++; if (err !== 1'b1) begin errors++; $display("FAIL err_stray got=%b exp=1", err); end
        tick();
        vectors++; if (err !== 1'b0) begin errors++; $display("FAIL err_stray_pulse got=%b exp=0", err); end
        $display("test_errors done");
    endtask

    task automatic test_reset_midburst;
        do_reset();
        ar_ready = 1'b1;
        req_addr[0*AW +: AW] = 10'h3F0; req_len[0*LW +: LW] = 4'd7;
        req_valid = 4'b0001;
        tick(); req_valid = 4'b0000;
        tick();
        data_stb = 1'b1; last = 1'b0; #1;
        vectors++; if (rd_stb !== 4'b0001) begin errors++; $display("FAIL rmb_beat1 got=%b exp=0001", rd_stb); end
        tick();
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (ar_valid !== 1'b0 || ar_addr !== 10'h000 || ar_len !== 4'h0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rmb_ar got=%b/%h/%h/%b exp=0/000/0/0000", ar_valid, ar_addr, ar_len, req_ready); end
        vectors++; if (rd_stb !== 4'b0000 || rd_last !== 1'b0 || outstanding !== 5'd0 || err !== 1'b0) begin errors++; $display("FAIL rmb_data got=%b/%b/%0d/%b exp=0000/0/0/0", rd_stb, rd_last, outstanding, err); end
        data_stb = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        data_stb = 1'b1; #1;
        vectors++; if (rd_stb !== 4'b0000) begin errors++; $display("FAIL rmb_stray_route got=%b exp=0000", rd_stb); end
        tick(); data_stb = 1'b0; #1;
        vectors++; if (err !== 1'b1) begin errors++; $display("FAIL rmb_stray_err got=%b exp=1", err); end
        tick();
        req_addr[3*AW +: AW] = 10'h011; req_len[3*LW +: LW] = 4'd0;
        req_valid = 4'b1000; #1;
        vectors++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rmb_grant got=%b exp=1000", req_ready); end
        tick(); req_valid = 4'b0000;
        tick();
        data_stb = 1'b1; last = 1'b1; #1;
        vectors++; if (rd_stb !== 4'b1000 || rd_last !== 1'b1) begin errors++; $display("FAIL rmb_beat got=%b/%b exp=1000/1", rd_stb, rd_last); end
        tick(); data_stb = 1'b0; last = 1'b0; #1;
        vectors++; if (err !== 1'b0 || outstanding !== 5'd0) begin errors++; $display("FAIL rmb_done got err=%b out=%0d exp=0/0", err, outstanding); end
        $display("test_reset_midburst done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_interleave();
        test_errors();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
